// File: rtl/somador_pkg.sv
// Shared types and constants for the two-requester sum-job scheduler.
// State encoding, field widths and the job-length clamp.
package somador_pkg;

  localparam int ADDR_W  = 5;
  localparam int LEN_W   = 6;
  localparam int MAX_LEN = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    READ   = 3'd2,
    ACCUM  = 3'd3,
    TRANSF = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Lengths beyond the memory size would only revisit the same words.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/somador_scheduler_arb.sv
// Two-way round-robin arbiter, combinational one-hot grant, 0-cycle latency.
// Priority pointer moves to the other requester only when a grant is issued.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req[0] && (!i_req[1] || !r_ptr))
        o_gnt = 2'b01;
      else if (i_req[1])
        o_gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= 1'b0;
    else if (o_gnt[0])
      r_ptr <= 1'b1;
    else if (o_gnt[1])
      r_ptr <= 1'b0;
  end

endmodule

// File: rtl/somador_scheduler.sv
// Sum-job scheduler driving the memory/accumulator strobes; 2*len+4 cycles grant to done.
// Requests are accepted only in IDLE; ready is a same-cycle combinational grant.
module somador_scheduler
  import somador_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_base,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic [ADDR_W-1:0] req0_dest,
  output logic              req0_ready,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_base,
  input  logic [LEN_W-1:0]  req1_len,
  input  logic [ADDR_W-1:0] req1_dest,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  output logic              load,
  output logic              clear,
  output logic              transf,
  output logic              wren,
  output logic              busy
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_dest;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic              r_id;
  logic              r_rden;
  logic              r_load;
  logic              r_clear;
  logic              r_transf;
  logic              r_wren;
  logic              r_done0;
  logic              r_done1;

  logic [1:0]        w_grant;
  logic              w_arb_en;
  logic [ADDR_W-1:0] w_sel_base;
  logic [ADDR_W-1:0] w_sel_dest;
  logic [LEN_W-1:0]  w_sel_len;
  logic [LEN_W-1:0]  w_idx_nxt;

  assign w_arb_en = (r_state == IDLE) && !reset;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req ({req1_valid, req0_valid}),
    .i_en  (w_arb_en),
    .o_gnt (w_grant)
  );

  assign w_sel_base = w_grant[1] ? req1_base : req0_base;
  assign w_sel_len  = w_grant[1] ? req1_len  : req0_len;
  assign w_sel_dest = w_grant[1] ? req1_dest : req0_dest;
  assign w_idx_nxt  = r_idx + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_dest   <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_id     <= 1'b0;
      r_rden   <= 1'b0;
      r_load   <= 1'b0;
      r_clear  <= 1'b0;
      r_transf <= 1'b0;
      r_wren   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
    end else begin
      // Strobes are single-cycle; each state arms only the next one.
      r_rden   <= 1'b0;
      r_load   <= 1'b0;
      r_clear  <= 1'b0;
      r_transf <= 1'b0;
      r_wren   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_base  <= w_sel_base;
            r_len   <= clamp_len(w_sel_len);
            r_dest  <= w_sel_dest;
            r_id    <= w_grant[1];
            r_clear <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_idx <= '0;
          if (r_len == '0) begin
            r_transf <= 1'b1;
            r_state  <= TRANSF;
          end else begin
            r_addr  <= r_base;
            r_rden  <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          r_load  <= 1'b1;
          r_state <= ACCUM;
        end
        ACCUM: begin
          r_idx <= w_idx_nxt;
          if (w_idx_nxt == r_len) begin
            r_transf <= 1'b1;
            r_state  <= TRANSF;
          end else begin
            r_addr  <= r_base + w_idx_nxt[ADDR_W-1:0];
            r_rden  <= 1'b1;
            r_state <= READ;
          end
        end
        TRANSF: begin
          r_addr  <= r_dest;
          r_wren  <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          r_done0 <= !r_id;
          r_done1 <= r_id;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign req0_done  = r_done0;
  assign req1_done  = r_done1;
  assign address    = r_addr;
  assign rden       = r_rden;
  assign load       = r_load;
  assign clear      = r_clear;
  assign transf     = r_transf;
  assign wren       = r_wren;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_somador_scheduler.sv
// Scoreboard bench: each grant expands into the expected strobe trace with cycle stamps,
// and a monitor pops and compares every strobe/done the scheduler emits.
module tb_somador_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [4:0] req0_base, req0_dest, req1_base, req1_dest;
  logic [5:0] req0_len, req1_len;
  logic       req0_ready, req0_done, req1_ready, req1_done;
  logic [4:0] address;
  logic       rden, load, clear, transf, wren, busy;

  somador_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_base(req0_base), .req0_len(req0_len),
    .req0_dest(req0_dest), .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_base(req1_base), .req1_len(req1_len),
    .req1_dest(req1_dest), .req1_ready(req1_ready), .req1_done(req1_done),
    .address(address), .rden(rden), .load(load), .clear(clear),
    .transf(transf), .wren(wren), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind: 1 clear, 2 rden, 3 load, 4 transf, 5 wren, 6 done0, 7 done1
  typedef struct {
    int kind;
    int addr;
    int cyc;
    int sum;
  } op_t;

  op_t         exp_q[$];
  int          grant_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          favor = 0;
  int          n_rden = 0;
  logic [15:0] mem[32];
  logic [15:0] acc, rdata, wd;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Expected trace for one accepted job, stamped with the cycle each strobe is due.
  task automatic push_job(input int id, input int base, input int len, input int dest);
    int L, c;
    logic [15:0] s;
    L = (len > 32) ? 32 : len;
    c = cyc + 1;
    s = 16'd0;
    exp_q.push_back('{1, 0, c, 0}); c++;
    for (int i = 0; i < L; i++) begin
      s = s + mem[(base + i) % 32];
      exp_q.push_back('{2, (base + i) % 32, c, 0}); c++;
      exp_q.push_back('{3, (base + i) % 32, c, 0}); c++;
    end
    exp_q.push_back('{4, 0, c, 0}); c++;
    exp_q.push_back('{5, dest, c, 0}); c++;
    exp_q.push_back('{6 + id, dest, c, int'(s)});
  endtask

  initial forever begin
    @(negedge clk);
    begin
      automatic int eg = -1;
      automatic int kind = 0;
      automatic int nstr;
      automatic op_t e;
      if (reset) begin
        exp_q.delete();
        favor = 0;
      end else begin
        check("busy", int'(busy), int'(exp_q.size() != 0));
        if (exp_q.size() == 0) begin
          if (req0_valid && req1_valid) eg = favor;
          else if (req0_valid)          eg = 0;
          else if (req1_valid)          eg = 1;
        end
        check("ready", int'({req1_ready, req0_ready}), (eg == 0) ? 1 : (eg == 1) ? 2 : 0);
        if (req0_ready && req0_valid) grant_log.push_back(0);
        if (req1_ready && req1_valid) grant_log.push_back(1);

        nstr = int'(clear) + int'(rden) + int'(load) + int'(transf) + int'(wren)
             + int'(req0_done) + int'(req1_done);
        if (clear)     kind = 1;
        if (rden)      kind = 2;
        if (load)      kind = 3;
        if (transf)    kind = 4;
        if (wren)      kind = 5;
        if (req0_done) kind = 6;
        if (req1_done) kind = 7;
        if (nstr > 1) check("one_strobe", nstr, 1);
        if (rden) n_rden++;
        if (nstr > 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_op", kind, 0);
          end else begin
            e = exp_q.pop_front();
            check("op_kind", kind, e.kind);
            check("op_cycle", cyc, e.cyc);
            if (kind == 2 || kind == 3 || kind == 5) check("op_addr", int'(address), e.addr);
            if (kind >= 6) check("result_word", int'(mem[e.addr]), e.sum);
          end
        end
        if (eg == 0) push_job(0, int'(req0_base), int'(req0_len), int'(req0_dest));
        if (eg == 1) push_job(1, int'(req1_base), int'(req1_len), int'(req1_dest));
        if (eg >= 0) favor = 1 - eg;
      end
      // Memory/accumulator behaviour driven by the observed strobes.
      if (clear)  acc = 16'd0;
      if (load)   acc = acc + rdata;
      if (transf) wd = acc;
      if (wren)   mem[address] = wd;
      if (rden)   rdata = mem[address];
    end
  end

  task automatic set_req(input int id, input logic v, input int b, input int l, input int d);
    if (id == 0) begin
      req0_valid = v; req0_base = 5'(b); req0_len = 6'(l); req0_dest = 5'(d);
    end else begin
      req1_valid = v; req1_base = 5'(b); req1_len = 6'(l); req1_dest = 5'(d);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the job.
  task automatic issue(input int id, input int b, input int l, input int d, input bit churn);
    int k;
    set_req(id, 1'b1, b, l, d);
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) break;
      if (churn) begin
        @(posedge clk); #1;
        set_req(id, 1'b1, $urandom_range(0, 31), $urandom_range(0, 40), $urandom_range(0, 31));
      end
    end
    if (k == 400) check("grant_timeout", id, -1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    if (k == 500) check("idle_timeout", k, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int alt_exp[5];
    int r0;
    alt_exp = '{0, 1, 0, 1, 0};
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    acc = 16'd0; rdata = 16'd0; wd = 16'd0;
    reset = 1'b1;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", int'({rden, load, clear, transf, wren, req0_done, req1_done, busy}), 0);
    check("rst_address", int'(address), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(0, 3, 4, 20, 0);  wait_idle();
    issue(1, 30, 4, 0, 0);  wait_idle();

    grant_log.delete();
    fork
      issue(0, 10, 2, 11, 0);
      issue(1, 12, 3, 13, 0);
    join
    wait_idle();
    check("both_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("both_second", grant_log.size() > 1 ? grant_log[1] : -1, 1);

    grant_log.delete();
    fork
      begin repeat (3) issue(0, $urandom_range(0, 31), $urandom_range(0, 6), $urandom_range(0, 31), 0); end
      begin repeat (2) issue(1, $urandom_range(0, 31), $urandom_range(0, 6), $urandom_range(0, 31), 0); end
    join
    wait_idle();
    check("alt_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("alt_order", grant_log[i], alt_exp[i]);

    issue(0, 9, 0, 7, 0);  wait_idle();

    r0 = n_rden;
    issue(1, 25, 40, 12, 0);  wait_idle();
    check("clamp_rden_pulses", n_rden - r0, 32);

    // Reset during WRITE drops the job without a done pulse.
    issue(0, 5, 3, 9, 0);
    for (int k = 0; k < 100; k++) begin
      if (wren) break;
      @(posedge clk); #1;
    end
    check("saw_write", int'(wren), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_wren", int'(wren), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'({req1_done, req0_done}), 0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_rst", int'({req1_done, req0_done}), 0);
    end
    @(posedge clk); #1;

    fork
      begin
        repeat (15) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #1;
          issue(0, $urandom_range(0, 31), $urandom_range(0, 40), $urandom_range(0, 31), 1);
        end
      end
      begin
        repeat (15) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #1;
          issue(1, $urandom_range(0, 31), $urandom_range(0, 40), $urandom_range(0, 31), 1);
        end
      end
    join
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/somador_scheduler.md
Name: somador_scheduler

Overview:
Two-requester job scheduler for the 32-word memory + accumulator datapath.
- Each requester submits a sum job (base address, word count, destination address) over a valid/ready handshake.
- The block arbitrates round-robin between the two requesters and drives the datapath strobes (address, rden, load, clear, transf, wren) to sum the words and write the result to the destination.
- Sits between client logic and the memory/accumulator datapath; replaces direct client control of those strobes.

Parameters:
- ADDR_W, 5, memory address width (32 words)
- LEN_W, 6, job length field width; valid lengths 0..2**ADDR_W

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req0_valid  in  1  requester 0 job pending; held until accepted
- req0_base  in  ADDR_W  requester 0 first source address
- req0_len  in  LEN_W  requester 0 number of words to sum
- req0_dest  in  ADDR_W  requester 0 result address
- req0_ready  out  1  job accept strobe for requester 0
- req0_done  out  1  one-cycle pulse, requester 0 job written
- req1_valid, req1_base, req1_len, req1_dest, req1_ready, req1_done: same as requester 0, for requester 1
- address  out  ADDR_W  memory address
- rden  out  1  memory read enable (data valid next cycle)
- load  out  1  accumulator <= accumulator + memory data
- clear  out  1  accumulator <= 0
- transf  out  1  accumulator -> write-data register
- wren  out  1  write-data register -> memory[address]
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, high): state IDLE; all outputs 0; address 0; round-robin pointer favours requester 0; any in-flight job is dropped, and no done pulse is issued for it.
- States: IDLE, CLEAR, READ, ACCUM, TRANSF, WRITE, DONE.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant the requester the pointer favours.
  - On grant, reqN_ready = 1 combinationally in that same cycle. base, len (clamped to 32 if > 32), dest and the requester id are captured. Pointer moves to the other requester. Next state is CLEAR.
- CLEAR: clear = 1 for one cycle. Element index i = 0. If len = 0, go to TRANSF; otherwise go to READ.
- READ: address = (base + i) mod 32, rden = 1. Next state is ACCUM.
- ACCUM: load = 1, address held. Then i++. If i = len, go to TRANSF; otherwise go to READ.
- TRANSF: transf = 1. Next state is WRITE.
- WRITE: address = dest, wren = 1. Next state is DONE.
- DONE: reqN_done = 1 for the captured requester. Next state is IDLE. A new job can be granted no earlier than the cycle after DONE.
- Latency: from the grant cycle to the DONE cycle is 2*len + 4 cycles.
- At most one strobe among rden/load/clear/transf/wren is high in any cycle.
- Address arithmetic is ADDR_W bits and wraps silently (31 -> 0).
- req inputs are ignored outside IDLE.
- Changing reqN fields while valid and not yet accepted is legal; values are sampled only in the grant cycle.
- dest may lie inside the source range; the read phase completes before the write, so no hazard.

Decomposition:
- Shared package somador_pkg:
  - state enumeration: IDLE=0, CLEAR=1, READ=2, ACCUM=3, TRANSF=4, WRITE=5, DONE=6
  - ADDR_W, LEN_W and MAX_LEN = 32 constants
- One sub-module, rr_arbiter_2: two request inputs, a grant-enable input, and a one-hot grant output. It owns the priority pointer and updates it only when grant-enable is high.

Test Plan:
- Reset -> all outputs 0 and busy 0. Assert reset in WRITE -> next cycle wren = 0, state IDLE, no done pulse.
- req0 job base=3, len=4, dest=20 -> addresses 3, 4, 5, 6, each READ followed by ACCUM. Then transf, then wren with address=20. req0_done pulses exactly 12 cycles after req0_ready.
- req1 job base=30, len=4, dest=0 -> read addresses 30, 31, 0, 1 in order, then write to address 0.
- Both valid in the same cycle after reset -> req0 granted first, req1 granted the cycle after req0's DONE. With req0 re-asserted continuously, grants alternate 0, 1, 0, 1.
- len=0, dest=7 -> clear, transf, then wren at address 7. rden and load never asserted. Done 4 cycles after grant.
- len=40 -> clamped to 32: exactly 32 rden pulses covering all addresses from base around the wrap.
